// File: rtl/ula_ctrl_md_pkg.sv
// Shared encodings for the EX-stage ALU control and the multiply/divide sequencer.
package ula_ctrl_md_pkg;

    localparam logic [3:0] ALUOP_LW_SW  = 4'd0;
    localparam logic [3:0] ALUOP_BRANCH = 4'd1;
    localparam logic [3:0] ALUOP_RTYPE  = 4'd2;
    localparam logic [3:0] ALUOP_AND    = 4'd3;
    localparam logic [3:0] ALUOP_OR     = 4'd4;
    localparam logic [3:0] ALUOP_XOR    = 4'd5;
    localparam logic [3:0] ALUOP_LUI    = 4'd6;
    localparam logic [3:0] ALUOP_SLT    = 4'd7;
    localparam logic [3:0] ALUOP_SLTU   = 4'd8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_MFHI = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_SLLV  = 6'h04;
    localparam logic [5:0] FUNCT_SRLV  = 6'h06;
    localparam logic [5:0] FUNCT_SRAV  = 6'h07;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction

endpackage

// File: rtl/ula_ctrl_md_iter.sv
// Iterative multiply/divide datapath: magnitude capture, one bit per step, sign fix on the way out.
module ula_ctrl_md_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_div0
);
    localparam int W2 = 2 * DATA_W;

    logic              w_is_div, w_sa, w_sb;
    logic [DATA_W-1:0] w_a_mag, w_b_mag;
    logic [W2-1:0]     r_acc, w_acc_next, w_prod;
    logic [DATA_W-1:0] r_b, w_q, w_r;
    logic              r_is_div, r_neg_q, r_neg_r, r_div0;
    logic [DATA_W:0]   w_sum, w_rem_sh, w_rem_new;
    logic              w_ge;

    // i_op is funct[1:0]: bit1 selects divide, bit0 selects unsigned
    assign w_is_div = i_op[1];
    assign w_sa     = ~i_op[0] & i_rs[DATA_W-1];
    assign w_sb     = ~i_op[0] & i_rt[DATA_W-1];
    assign w_a_mag  = w_sa ? -i_rs : i_rs;
    assign w_b_mag  = w_sb ? -i_rt : i_rt;

    // acc = {partial product, multiplier} for mul, {remainder, dividend->quotient} for div
    always_comb begin
        w_sum      = {1'b0, r_acc[W2-1:DATA_W]} + {1'b0, (r_acc[0] ? r_b : {DATA_W{1'b0}})};
        w_rem_sh   = {r_acc[W2-1:DATA_W], r_acc[DATA_W-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_b});
        w_rem_new  = w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
        if (r_is_div) begin
            w_acc_next = {w_rem_new[DATA_W-1:0], r_acc[DATA_W-2:0], w_ge};
        end else begin
            w_acc_next = {w_sum, r_acc[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{DATA_W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_b      <= w_is_div ? w_b_mag : w_a_mag;
            r_is_div <= w_is_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_div0   <= w_is_div & (i_rt == '0);
        end else if (i_step) begin
            r_acc    <= w_acc_next;
        end
    end

    // With a zero divisor every step subtracts nothing, leaving rem = |rs|; the sign fix restores rs
    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_q    = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
        w_r    = r_neg_r ? -r_acc[W2-1:DATA_W] : r_acc[W2-1:DATA_W];
        if (r_is_div) begin
            o_hi = w_r;
            o_lo = r_div0 ? {DATA_W{1'b1}} : w_q;
        end else begin
            o_hi = w_prod[W2-1:DATA_W];
            o_lo = w_prod[DATA_W-1:0];
        end
    end

    assign o_div0 = r_div0;

endmodule

// File: rtl/ula_ctrl_md.sv
// EX-stage ALU control decode plus multiply/divide sequencer owning the HI/LO registers.
module ula_ctrl_md
    import ula_ctrl_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [3:0]        ALUOp,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [3:0]        ALUControl,
    output logic              stall_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div0_o
);
    md_state_e         r_state, w_next;
    logic [5:0]        r_cnt;
    logic [DATA_W-1:0] r_hi, r_lo, w_md_hi, w_md_lo;
    logic              w_rtype, w_md_req, w_idle_ok, w_start, w_step, w_wr_hilo;
    logic              w_cnt_last, w_div0;

    always_comb begin
        ALUControl = OP_ADD;
        case (ALUOp)
            ALUOP_LW_SW:  ALUControl = OP_ADD;
            ALUOP_BRANCH: ALUControl = OP_SUB;
            ALUOP_AND:    ALUControl = OP_AND;
            ALUOP_OR:     ALUControl = OP_OR;
            ALUOP_XOR:    ALUControl = OP_XOR;
            ALUOP_LUI:    ALUControl = OP_LUI;
            ALUOP_SLT:    ALUControl = OP_SLT;
            ALUOP_SLTU:   ALUControl = OP_SLTU;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: ALUControl = OP_ADD;
                    FUNCT_SUB, FUNCT_SUBU: ALUControl = OP_SUB;
                    FUNCT_AND:             ALUControl = OP_AND;
                    FUNCT_OR:              ALUControl = OP_OR;
                    FUNCT_XOR:             ALUControl = OP_XOR;
                    FUNCT_NOR:             ALUControl = OP_NOR;
                    FUNCT_SLT:             ALUControl = OP_SLT;
                    FUNCT_SLTU:            ALUControl = OP_SLTU;
                    FUNCT_SLL, FUNCT_SLLV: ALUControl = OP_SLL;
                    FUNCT_SRL, FUNCT_SRLV: ALUControl = OP_SRL;
                    FUNCT_SRA, FUNCT_SRAV: ALUControl = OP_SRA;
                    FUNCT_MFHI:            ALUControl = OP_MFHI;
                    FUNCT_MFLO:            ALUControl = OP_MFLO;
                    default:               ALUControl = OP_ADD;
                endcase
            end
            default: ALUControl = OP_ADD;
        endcase
    end

    assign w_rtype    = valid_i & (ALUOp == ALUOP_RTYPE);
    assign w_md_req   = w_rtype & is_md_funct(funct);
    assign w_idle_ok  = (r_state == ST_IDLE) & ~flush_i;
    assign w_start    = w_idle_ok & w_md_req;
    assign w_cnt_last = (r_cnt == 6'(DATA_W - 1));

    always_comb begin
        w_next    = r_state;
        w_step    = 1'b0;
        w_wr_hilo = 1'b0;
        stall_o   = 1'b0;
        div0_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next  = ST_RUN;
                    stall_o = 1'b1;
                end
            end
            ST_RUN: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    w_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_cnt_last) w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_next    = ST_IDLE;
                w_wr_hilo = ~flush_i;
                div0_o    = ~flush_i & w_div0;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_step ? r_cnt + 6'd1 : 6'd0;
        end
    end

    // A retiring mul/div owns HI/LO in FIX; MTHI/MTLO only land while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_wr_hilo) begin
            r_hi <= w_md_hi;
            r_lo <= w_md_lo;
        end else begin
            if (w_idle_ok & w_rtype & (funct == FUNCT_MTHI)) r_hi <= rs_val;
            if (w_idle_ok & w_rtype & (funct == FUNCT_MTLO)) r_lo <= rs_val;
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

    ula_ctrl_md_iter #(
        .DATA_W (DATA_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_start),
        .i_step (w_step),
        .i_op   (funct[1:0]),
        .i_rs   (rs_val),
        .i_rt   (rt_val),
        .o_hi   (w_md_hi),
        .o_lo   (w_md_lo),
        .o_div0 (w_div0)
    );

endmodule
